// File: rtl/rfid_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rfid_reader_if
// Brief    : Deserialises 10-bit parity-protected RFID frames, submits the tag
//            ID to a door controller and tracks its granted/denied response.
// Revision : 1.0
// ============================================================================
module rfid_reader_if #(
    parameter int GAP_TIMEOUT  = 16,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_data,
    input  logic       granted,
    input  logic       denied,
    output logic [7:0] rfid_out,
    output logic       submit,
    output logic       busy,
    output logic       frame_err,
    output logic       resp_timeout,
    output logic       overrun,
    output logic       last_ok
);

    localparam int c_GAP_W  = $clog2(GAP_TIMEOUT + 1);
    localparam int c_RESP_W = $clog2(RESP_TIMEOUT + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_SHIFT     = 2'd1;
    localparam logic [1:0] c_WAIT_RESP = 2'd2;

    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_RESP_W-1:0] c_RESP_LAST = c_RESP_W'(RESP_TIMEOUT - 1);
    localparam logic [c_RESP_W-1:0] c_RESP_ONE  = c_RESP_W'(1);
    localparam logic [3:0]          c_LAST_BIT  = 4'd9;

    logic [1:0]          r_state;
    logic [3:0]          r_bit_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [c_RESP_W-1:0] r_resp_cnt;
    logic [8:0]          r_shift;
    logic [7:0]          r_rfid_out;
    logic                r_submit;
    logic                r_busy;
    logic                r_frame_err;
    logic                r_resp_timeout;
    logic                r_overrun;
    logic                r_last_ok;

    logic [1:0]          w_state;
    logic [3:0]          w_bit_cnt;
    logic [c_GAP_W-1:0]  w_gap_cnt;
    logic [c_RESP_W-1:0] w_resp_cnt;
    logic [8:0]          w_shift;
    logic [7:0]          w_rfid_out;
    logic                w_submit;
    logic                w_frame_err;
    logic                w_resp_timeout;
    logic                w_overrun;
    logic                w_last_ok;
    logic [9:0]          w_frame;
    logic                w_parity_ok;

    // Complete frame as seen on the 10th bit: [9]=P_even, [8:1]=D7..D0, [0]=P_odd.
    assign w_frame     = {r_shift, bit_data};
    assign w_parity_ok = ~(^w_frame[9:5]) & (^w_frame[4:0]);

    always_comb begin
        w_state        = r_state;
        w_bit_cnt      = r_bit_cnt;
        w_gap_cnt      = r_gap_cnt;
        w_resp_cnt     = r_resp_cnt;
        w_shift        = r_shift;
        w_rfid_out     = r_rfid_out;
        w_last_ok      = r_last_ok;
        w_submit       = 1'b0;
        w_frame_err    = 1'b0;
        w_resp_timeout = 1'b0;
        w_overrun      = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (bit_valid) begin
                    w_state   = c_SHIFT;
                    w_shift   = {8'd0, bit_data};
                    w_bit_cnt = 4'd1;
                    w_gap_cnt = '0;
                end
            end

            c_SHIFT: begin
                if (bit_valid) begin
                    w_gap_cnt = '0;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_shift   = '0;
                        w_bit_cnt = '0;
                        if (w_parity_ok) begin
                            w_rfid_out = w_frame[8:1];
                            w_submit   = 1'b1;
                            w_resp_cnt = '0;
                            w_state    = c_WAIT_RESP;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state     = c_IDLE;
                        end
                    end else begin
                        w_shift   = {r_shift[7:0], bit_data};
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_frame_err = 1'b1;
                    w_shift     = '0;
                    w_bit_cnt   = '0;
                    w_gap_cnt   = '0;
                    w_state     = c_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + c_GAP_ONE;
                end
            end

            c_WAIT_RESP: begin
                // Incoming bits are dropped here; only the overrun pulse records them.
                w_overrun = bit_valid;
                if (denied) begin
                    w_last_ok  = 1'b0;
                    w_resp_cnt = '0;
                    w_state    = c_IDLE;
                end else if (granted) begin
                    w_last_ok  = 1'b1;
                    w_resp_cnt = '0;
                    w_state    = c_IDLE;
                end else if (r_resp_cnt == c_RESP_LAST) begin
                    w_resp_timeout = 1'b1;
                    w_last_ok      = 1'b0;
                    w_resp_cnt     = '0;
                    w_state        = c_IDLE;
                end else begin
                    w_resp_cnt = r_resp_cnt + c_RESP_ONE;
                end
            end

            default: begin
                w_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_resp_cnt     <= '0;
            r_shift        <= '0;
            r_rfid_out     <= 8'h00;
            r_submit       <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_err    <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_overrun      <= 1'b0;
            r_last_ok      <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_bit_cnt      <= w_bit_cnt;
            r_gap_cnt      <= w_gap_cnt;
            r_resp_cnt     <= w_resp_cnt;
            r_shift        <= w_shift;
            r_rfid_out     <= w_rfid_out;
            r_submit       <= w_submit;
            r_busy         <= (w_state != c_IDLE);
            r_frame_err    <= w_frame_err;
            r_resp_timeout <= w_resp_timeout;
            r_overrun      <= w_overrun;
            r_last_ok      <= w_last_ok;
        end
    end

    assign rfid_out     = r_rfid_out;
    assign submit       = r_submit;
    assign busy         = r_busy;
    assign frame_err    = r_frame_err;
    assign resp_timeout = r_resp_timeout;
    assign overrun      = r_overrun;
    assign last_ok      = r_last_ok;

endmodule
`default_nettype wire

// File: tb/tb_rfid_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_rfid_reader_if
// Brief    : Directed plus randomized transactions against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_rfid_reader_if;

    localparam int GAP_TIMEOUT  = 16;
    localparam int RESP_TIMEOUT = 8;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       bit_data;
    logic       granted;
    logic       denied;
    logic [7:0] rfid_out;
    logic       submit;
    logic       busy;
    logic       frame_err;
    logic       resp_timeout;
    logic       overrun;
    logic       last_ok;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_rfid;
    logic       exp_ok;

    rfid_reader_if #(
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .granted     (granted),
        .denied      (denied),
        .rfid_out    (rfid_out),
        .submit      (submit),
        .busy        (busy),
        .frame_err   (frame_err),
        .resp_timeout(resp_timeout),
        .overrun     (overrun),
        .last_ok     (last_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic sub, input logic fe,
                               input logic rto, input logic ovr, input logic bsy);
        chk({tag, ".submit"},       submit,       sub);
        chk({tag, ".frame_err"},    frame_err,    fe);
        chk({tag, ".resp_timeout"}, resp_timeout, rto);
        chk({tag, ".overrun"},      overrun,      ovr);
        chk({tag, ".busy"},         busy,         bsy);
        chk({tag, ".rfid_out"},     rfid_out,     exp_rfid);
        chk({tag, ".last_ok"},      last_ok,      exp_ok);
    endtask

    // Model: a frame is good when the upper group (P_even + high nibble) has an
    // even number of ones and the lower group (low nibble + P_odd) an odd number.
    function automatic bit parity_good(input logic [9:0] f);
        return (($countones(f[9:5]) % 2) == 0) && (($countones(f[4:0]) % 2) == 1);
    endfunction

    function automatic logic [9:0] make_frame(input logic [7:0] d);
        logic pe;
        logic po;
        pe = ($countones(d[7:4]) % 2) != 0;
        po = ($countones(d[3:0]) % 2) == 0;
        return {pe, d, po};
    endfunction

    // Sends a frame MSB-first with idle gaps in [gmin,gmax]; ends in the cycle
    // right after the 10th bit was sampled.
    task automatic send_frame(input logic [9:0] f, input int gmin, input int gmax, output bit ok);
        int g;
        ok = parity_good(f);
        for (int i = 9; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_data  = f[i];
            tick();
            bit_valid = 1'b0;
            bit_data  = 1'($urandom_range(0, 1));
            if (i > 0) begin
                expect_outs("frame_bit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                g = $urandom_range(gmax, gmin);
                repeat (g) begin
                    tick();
                    expect_outs("frame_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                end
            end
        end
        if (ok) begin
            exp_rfid = f[8:1];
            expect_outs("frame_submit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            expect_outs("frame_parity", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Called in the submit cycle (wait cycle 0). kind: 0 granted, 1 denied,
    // 2 both, 3 none. ovr_at: wait cycle carrying a stray bit, or -1.
    task automatic respond(input int delay, input int kind, input int ovr_at);
        bit done;
        bit resp_now;
        done = 1'b0;
        for (int c = 0; c < RESP_TIMEOUT && !done; c++) begin
            resp_now  = (kind != 3) && (c == delay);
            granted   = resp_now && (kind == 0 || kind == 2);
            denied    = resp_now && (kind == 1 || kind == 2);
            bit_valid = (c == ovr_at);
            bit_data  = 1'($urandom_range(0, 1));
            tick();
            granted   = 1'b0;
            denied    = 1'b0;
            bit_valid = 1'b0;
            if (resp_now) begin
                exp_ok = (kind == 0);
                done   = 1'b1;
                expect_outs("resp_done", 1'b0, 1'b0, 1'b0, c == ovr_at, 1'b0);
            end else if (c == RESP_TIMEOUT - 1) begin
                exp_ok = 1'b0;
                done   = 1'b1;
                expect_outs("resp_timeout", 1'b0, 1'b0, 1'b1, c == ovr_at, 1'b0);
            end else begin
                expect_outs("resp_wait", 1'b0, 1'b0, 1'b0, c == ovr_at, 1'b1);
            end
        end
        tick();
        expect_outs("resp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] f;
        logic [7:0] d;
        bit         ok;
        int         kind;
        int         delay;
        int         ovr;

        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        granted   = 1'b0;
        denied    = 1'b0;
        exp_rfid  = 8'h00;
        exp_ok    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Responses outside WAIT_RESP must not touch last_ok.
        granted = 1'b1;
        tick();
        granted = 1'b0;
        expect_outs("idle_grant", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0x21 granted two cycles after submit.
        send_frame(10'b1001000010, 0, 0, ok);
        respond(2, 0, -1);

        // 0xD3 denied, then granted, then granted+denied together.
        send_frame(10'b1110100111, 0, 1, ok);
        respond(2, 1, -1);
        send_frame(10'b1110100111, 0, 2, ok);
        respond(1, 0, -1);
        send_frame(10'b1110100111, 0, 0, ok);
        respond(3, 2, -1);

        // 0x21 with P_even cleared: frame_err, rfid_out unchanged.
        send_frame(10'b0001000010, 0, 0, ok);
        tick();
        expect_outs("after_parity_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Five bits then a full gap timeout.
        f = 10'b1001000010;
        for (int i = 9; i >= 5; i--) begin
            bit_valid = 1'b1;
            bit_data  = f[i];
            tick();
            bit_valid = 1'b0;
            expect_outs("partial", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int c = 1; c <= GAP_TIMEOUT; c++) begin
            tick();
            if (c < GAP_TIMEOUT)
                expect_outs("gap_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else
                expect_outs("gap_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        send_frame(10'b1001000010, 0, 0, ok);
        respond(0, 0, -1);

        // Longest legal gap between every bit, latest legal denial.
        d = 8'($urandom);
        send_frame(make_frame(d), GAP_TIMEOUT - 1, GAP_TIMEOUT - 1, ok);
        respond(RESP_TIMEOUT - 1, 1, -1);

        // No response: timeout, with a stray bit during the wait.
        send_frame(10'b1001000010, 0, 0, ok);
        respond(0, 3, 3);

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            f = make_frame(d);
            if ($urandom_range(0, 3) == 0)
                f = f ^ (10'b1 << $urandom_range(0, 9));
            send_frame(f, 0, 3, ok);
            if (ok) begin
                kind  = $urandom_range(0, 3);
                delay = $urandom_range(0, RESP_TIMEOUT - 1);
                ovr   = -1;
                if ($urandom_range(0, 1) == 1) begin
                    if (kind == 3)
                        ovr = $urandom_range(0, RESP_TIMEOUT - 1);
                    else if (delay > 0)
                        ovr = $urandom_range(0, delay - 1);
                end
                respond(delay, kind, ovr);
            end else begin
                denied = 1'($urandom_range(0, 1));
                tick();
                denied = 1'b0;
                expect_outs("post_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Reset after bit 6 abandons the frame; a clean frame follows.
        send_frame(10'b1001000010, 0, 0, ok);
        respond(1, 0, -1);
        f = 10'b1110100111;
        for (int i = 9; i >= 4; i--) begin
            bit_valid = 1'b1;
            bit_data  = f[i];
            tick();
            bit_valid = 1'b0;
        end
        #3;
        rst = 1'b1;
        #1;
        exp_rfid = 8'h00;
        exp_ok   = 1'b0;
        expect_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        expect_outs("reset_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(10'b1110100111, 0, 0, ok);
        respond(0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rfid_reader_if.md
RFID_READER_IF -- requirements
Module: rfid_reader_if

Interface
REQ-001 Parameter GAP_TIMEOUT, default 16: idle clock cycles allowed between bits inside a frame.
REQ-002 Parameter RESP_TIMEOUT, default 8: cycles allowed for a granted/denied response after submit.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bit_valid  input  1  one-cycle strobe; bit_data valid this cycle.
REQ-006 bit_data  input  1  serial frame bit from reader front end.
REQ-007 granted  input  1  access-granted pulse from door controller.
REQ-008 denied  input  1  access-denied pulse from door controller.
REQ-009 rfid_out  output  8  decoded tag ID presented to door controller.
REQ-010 submit  output  1  one-cycle pulse; rfid_out valid.
REQ-011 busy  output  1  high while a frame is in progress or a response is awaited.
REQ-012 frame_err  output  1  one-cycle pulse; parity failure or inter-bit gap timeout.
REQ-013 resp_timeout  output  1  one-cycle pulse; no response within RESP_TIMEOUT.
REQ-014 overrun  output  1  one-cycle pulse; bit_valid while awaiting response, bit dropped.
REQ-015 last_ok  output  1  result of last completed transaction (1 = granted).

Function
REQ-016 Frame: 10 bits in arrival order: P_even, D7, D6, ..., D0, P_odd.
REQ-017 Parity check: P_even XOR D7..D4 SHALL be 0; D3..D0 XOR P_odd SHALL be 1.
REQ-018 States: IDLE, SHIFT, WAIT_RESP; busy = (state != IDLE).
REQ-019 IDLE: bit_valid -> capture bit as bit 1, go to SHIFT; all other inputs ignored.
REQ-020 SHIFT: each bit_valid shifts in one bit and clears gap counter; bit count 1..10.
REQ-021 SHIFT: GAP_TIMEOUT consecutive cycles without bit_valid -> frame_err high next cycle, partial frame discarded, go to IDLE.
REQ-022 10th bit with parity good: on that edge rfid_out <= D7..D0, submit <= 1, go to WAIT_RESP; submit high exactly one cycle.
REQ-023 10th bit with parity bad: on that edge frame_err <= 1, no submit, rfid_out unchanged, go to IDLE.
REQ-024 rfid_out holds its value until the next good frame; it never changes while submit is high or in WAIT_RESP.
REQ-025 WAIT_RESP: response counter starts at 0 in the submit cycle and increments each cycle; granted/denied sampled every WAIT_RESP cycle, including the submit cycle.
REQ-026 granted alone -> last_ok <= 1, go to IDLE; denied alone -> last_ok <= 0, go to IDLE.
REQ-027 granted and denied in the same cycle -> treated as denied (last_ok <= 0).
REQ-028 No response in RESP_TIMEOUT cycles -> resp_timeout high next cycle, last_ok <= 0, go to IDLE.
REQ-029 bit_valid in WAIT_RESP -> bit dropped, overrun pulse next cycle, state unchanged.
REQ-030 granted/denied outside WAIT_RESP ignored; last_ok unchanged.
REQ-031 All outputs registered; a new frame SHALL be accepted starting in the cycle after returning to IDLE.

Reset
REQ-032 On rst: state IDLE, bit/gap/response counters 0, shift register 0, rfid_out 0x00, submit/frame_err/resp_timeout/overrun/last_ok 0, busy 0.
REQ-033 rst mid-frame or mid-WAIT_RESP abandons the transaction with no pulse outputs; the first bit_valid after rst release starts a new frame.

Verification
REQ-034 Frame 1,0,0,1,0,0,0,0,1,0 (0x21); granted 2 cycles after submit -> submit 1 cycle, rfid_out=0x21, last_ok=1, busy low next cycle.
REQ-035 Frame 1,1,1,0,1,0,0,1,1,1 (0xD3); denied 2 cycles after submit -> rfid_out=0xD3, last_ok=0; granted+denied same cycle on repeat -> last_ok=0.
REQ-036 0x21 frame with P_even=0 -> frame_err 1 cycle after 10th bit, no submit, rfid_out unchanged.
REQ-037 5 bits then 16 cycles without bit_valid -> frame_err, IDLE; following full 0x21 frame -> normal submit.
REQ-038 Good frame, no response -> resp_timeout 1 cycle after 8 WAIT_RESP cycles, last_ok=0; bit_valid during wait -> overrun pulse, no state change.
REQ-039 rst asserted after bit 6 -> all outputs at reset values, no submit; clean 0xD3 frame after release -> submit, rfid_out=0xD3.
